router_xbar_reg: RTL

- Parametrised successor to the router output-port crossbar mux.
- Selects one of NUM_PORTS input flits using the arbiter's encoded select and registers it into a 2-entry skid buffer.
- Presents the buffered flit to the downstream link with a valid/ready handshake.
- Returns a one-hot acknowledge to the winning input; sits between the per-port arbiter and the output link register.

---
 rtl/router_xbar_pkg.sv | 21 ++
 rtl/xbar_skid_buf.sv | 56 +++++
 rtl/router_xbar_reg.sv | 95 +++++++++
 3 files changed

// File: rtl/router_xbar_pkg.sv
// Shared constants for the router output-port crossbar: port IDs, idle select code,
// default flit width and a ceil-log2 helper used to validate select widths.
package router_xbar_pkg;

  localparam logic [2:0] W_PORT    = 3'd0;
  localparam logic [2:0] S_PORT    = 3'd1;
  localparam logic [2:0] L_PORT    = 3'd2;
  localparam logic [2:0] N_PORT    = 3'd3;
  localparam logic [2:0] E_PORT    = 3'd4;
  localparam logic [2:0] PORT_IDLE = 3'b111;

  localparam int DATA_WIDTH_DEF = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/xbar_skid_buf.sv
// Two-entry in-order flit buffer; entry 0 is the head. Entries at or beyond the
// current count are kept at zero so the head reads 0 whenever the buffer is empty.
module xbar_skid_buf
  import router_xbar_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]            count_q, count_d;
  logic                  do_push, do_pop;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && (count_q != 2'd2);
    // Pop first so a simultaneous push lands in the slot the pop just freed.
    if (do_pop) begin
      ent0_d  = ent1_q;
      ent1_d  = '0;
      count_d = count_q - 2'd1;
    end
    if (do_push) begin
      if (count_d == 2'd0) ent0_d = wdata;
      else                 ent1_d = wdata;
      count_d = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign rdata = ent0_q;
  assign count = count_q;

endmodule

// File: rtl/router_xbar_reg.sv
// Output-port crossbar: decodes the arbiter select, muxes the winning flit into a
// skid buffer and acks the winner. Optional counters under ROUTER_XBAR_STATS_EN.
module router_xbar_reg
  import router_xbar_pkg::*;
#(
  parameter int NUM_PORTS  = 5,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SEL_W      = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SEL_W-1:0]                sel_in,
  input  logic                            sel_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
  output logic [NUM_PORTS-1:0]            in_ack,
  output logic [DATA_WIDTH-1:0]           dataout,
  output logic                            validout,
  input  logic                            ready_in,
  output logic [1:0]                      occupancy
`ifdef ROUTER_XBAR_STATS_EN
  ,
  output logic [15:0]                     flit_cnt,
  output logic [15:0]                     stall_cnt
`endif
);

  // At least one select code must be left over to mean idle.
  if (SEL_W < clog2(NUM_PORTS + 1)) begin : g_sel_w_check
    $error("router_xbar_reg: SEL_W too narrow for NUM_PORTS");
  end

  localparam logic [SEL_W:0] NUM_PORTS_W = (SEL_W + 1)'(NUM_PORTS);

  logic                  hit, push, pop;
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] mux_data;

  assign hit = sel_valid && ({1'b0, sel_in} < NUM_PORTS_W);
  // Acceptance looks only at the registered count, keeping ready_in off the ack path.
  assign push = hit && !rst && (count != 2'd2);
  assign pop  = validout && ready_in;

  always_comb begin
    mux_data = '0;
    in_ack   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (sel_in == SEL_W'(p)) begin
        mux_data  = data_in[p*DATA_WIDTH +: DATA_WIDTH];
        in_ack[p] = push;
      end
    end
  end

  xbar_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (mux_data),
    .rdata (dataout),
    .count (count)
  );

  assign validout  = (count != 2'd0);
  assign occupancy = count;

`ifdef ROUTER_XBAR_STATS_EN
  logic [15:0] flit_cnt_q, flit_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    flit_cnt_d  = flit_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pop) flit_cnt_d = flit_cnt_q + 16'd1;
    if (hit && (count == 2'd2) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flit_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      flit_cnt_q  <= flit_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flit_cnt  = flit_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
